// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;
   localparam int PC_STEP = 4;
   localparam int IR_W    = 32;

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_DROP} fetch_state_t;
   typedef enum logic [1:0] {I_READY, I_BUSY, I_DONE, I_GUARD} issue_state_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - memory, decoder and redirect signals of the fetch stage
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int AW = 16
);
   logic            en;
   logic            mem_req;
   logic [AW-1:0]   mem_addr;
   logic            mem_ack;
   logic [IR_W-1:0] mem_rdata;
   logic [IR_W-1:0] ir;
   logic            cs;
   logic            ready1;
   logic            br_valid;
   logic [AW-1:0]   br_target;
   logic [AW-1:0]   pc;

   modport master (
      input  en, mem_ack, mem_rdata, ready1, br_valid, br_target,
      output mem_req, mem_addr, ir, cs, pc
   );

   modport slave (
      output en, mem_ack, mem_rdata, ready1, br_valid, br_target,
      input  mem_req, mem_addr, ir, cs, pc
   );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - shift-style instruction buffer; flush beats push and pop
module fetch_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] count;
   logic [CW-1:0] wr_idx;
   logic [W-1:0]  mem [DEPTH];
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign head    = mem[0];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Head always lives in slot 0, so a simultaneous pop shifts the write slot down.
   assign wr_idx  = do_pop ? count - 1'b1 : count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (flush)
         count <= '0;
      else
         count <= count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH - 1; i++)
         if (do_pop) mem[i] <= mem[i + 1];
      for (int i = 0; i < DEPTH; i++)
         if (do_push && !flush && wr_idx == CW'(i)) mem[i] <= din;
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, memory fetch FSM and decoder issue FSM
// Define FETCH_PREFETCH_EN for a 2-deep buffer overlapping fetch with decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input logic     clk,
   input logic     rst_n,
   fetch_if.master bus
);
`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   fetch_state_t    f_state, f_next;
   issue_state_t    i_state, i_next;
   logic [AW-1:0]   pc_q, pc_next, addr_q, addr_next;
   logic [IR_W-1:0] ir_q, head;
   logic            cs_q, push, pop, full, empty;

   fetch_fifo #(.W(IR_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (bus.mem_rdata),
      .pop   (pop),
      .flush (bus.br_valid),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign bus.mem_req  = (f_state != F_IDLE);
   assign bus.mem_addr = addr_q;
   assign bus.pc       = pc_q;
   assign bus.ir       = ir_q;
   assign bus.cs       = cs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_state <= F_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= '0;
      end else begin
         f_state <= f_next;
         pc_q    <= pc_next;
         addr_q  <= addr_next;
      end
   end

   always_comb begin
      f_next    = f_state;
      pc_next   = pc_q;
      addr_next = addr_q;
      push      = 1'b0;
      case (f_state)
         F_IDLE:
            if (!bus.br_valid && bus.en && !full) begin
               f_next    = F_REQ;
               addr_next = pc_q;
            end
         F_REQ:
            if (bus.br_valid)
               f_next = bus.mem_ack ? F_IDLE : F_DROP;
            else if (bus.mem_ack) begin
               push    = 1'b1;
               pc_next = pc_q + AW'(PC_STEP);
               f_next  = F_IDLE;
            end
         // Wrong-path read still owns the bus; wait it out at the old address.
         F_DROP:
            if (bus.mem_ack) f_next = F_IDLE;
         default:
            f_next = F_IDLE;
      endcase
      if (bus.br_valid) pc_next = bus.br_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_state <= I_READY;
         ir_q    <= '0;
         cs_q    <= 1'b0;
      end else begin
         i_state <= i_next;
         cs_q    <= pop;
         if (pop) ir_q <= head;
      end
   end

   always_comb begin
      i_next = i_state;
      pop    = 1'b0;
      case (i_state)
         I_READY:
            if (!bus.br_valid && !empty && bus.ready1) begin
               pop    = 1'b1;
               i_next = I_BUSY;
            end
         I_BUSY:  if (!bus.ready1) i_next = I_DONE;
         I_DONE:  if (bus.ready1) i_next = I_GUARD;
         // One dead cycle so the decoder settles before it can see cs again.
         I_GUARD: i_next = I_READY;
         default: i_next = I_READY;
      endcase
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the instruction decoder. Holds the program counter and reads 32-bit instruction words from memory over a req/ack handshake. Buffers fetched words and presents them to the decoder on `ir` with a one-cycle `cs` strobe, pacing issue with the decoder's `ready1`. Accepts branch redirects from the flow-control unit, which flush buffered and in-flight wrong-path words.

## Interface
Parameters:
- `AW`, 16, address width of `pc`, `mem_addr` and `br_target`.
- `RESET_PC`, 0, PC value loaded at reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  fetch enable; when low, no new memory request starts.
- `mem_req`  out  1  memory read request, held until acknowledged.
- `mem_addr`  out  AW  read address, stable while `mem_req` is high.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  32  instruction word.
- `ir`  out  32  instruction presented to the decoder.
- `cs`  out  1  one-cycle issue strobe to the decoder.
- `ready1`  in  1  decoder idle/complete indication.
- `br_valid`  in  1  one-cycle redirect request.
- `br_target`  in  AW  redirect address.
- `pc`  out  AW  address of the next word to fetch.

## Operation
- Reset values:
  - `pc` = `RESET_PC`.
  - `mem_req`, `cs` = 0.
  - `mem_addr`, `ir` = 0.
  - Buffer empty; fetch FSM in F_IDLE; issue FSM in I_READY.
- Fetch FSM:
  - F_IDLE → F_REQ when `en` is high and the buffer is not full.
  - F_REQ drives `mem_req`=1 and `mem_addr`=`pc`.
    - On `mem_ack`: push `mem_rdata`, set `pc`+=4 (modulo 2^AW, wraps silently), then go to F_IDLE.
  - F_DROP is used only after a redirect while a request is outstanding.
    - Keeps `mem_req`=1 at the old address.
    - On `mem_ack`, discards the data and returns to F_IDLE.
- Issue FSM:
  - I_READY: when the buffer is non-empty and `ready1`=1, pop the head into `ir`, pulse `cs` for one cycle, then go to I_BUSY.
  - I_BUSY waits for `ready1`=0, then goes to I_DONE.
  - I_DONE waits for `ready1`=1, then goes to I_GUARD.
  - I_GUARD lasts one cycle, then returns to I_READY.
    - This gives the decoder time to return to its idle state before it can sample `cs` again.
- `ir` holds its value until the next issue.
- Redirect (`br_valid`=1) takes priority over every other event:
  - Buffer flushed.
  - `pc` set to `br_target`.
  - `cs` forced to 0 in that cycle.
  - If `mem_req` is high and `mem_ack` is low in that cycle, the fetch FSM goes to F_DROP; otherwise it goes to F_IDLE.
  - A `mem_ack` in the same cycle as `br_valid` is discarded.
  - The issue FSM is unaffected.
- Buffer full: the fetch FSM stays in F_IDLE. Buffer empty: no issue.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- `en` dropping mid-request does not cancel the request; the outstanding read completes and its word is pushed.
- Reset asserted mid-operation returns everything to reset values immediately. Any outstanding memory read is abandoned.

## Timing
- Zero-wait memory: `mem_ack` may be high in the same cycle as `mem_req`.
- Fetch latency: request to buffered word is 1 cycle after `mem_ack`.
- Issue latency: with the buffer empty and the decoder ready, `cs` is high 1 cycle after the `mem_ack` edge that pushes the word.
- Minimum spacing between `cs` pulses is 4 cycles, bounded by the decoder's `ready1` timing.
- `pc` update after `br_valid` is visible 1 cycle later. The first redirected `mem_req` is asserted no earlier than the following cycle.

## Configuration
- `FETCH_PREFETCH_EN`:
  - Defined: the instruction buffer is 2 entries deep, so fetching overlaps decode.
  - Undefined: the buffer is 1 entry. A new fetch starts only after the previous word has been issued, giving strictly serial fetch/issue.
- The redirect, handshake and reset rules are identical in both builds.

## Structure
- Shared package `fetch_pkg`:
  - Fetch state enum (F_IDLE, F_REQ, F_DROP).
  - Issue state enum (I_READY, I_BUSY, I_DONE, I_GUARD).
  - `PC_STEP`=4.
  - `IR_W`=32.
- Sub-module `fetch_fifo`:
  - Parameterised-depth synchronous FIFO with push, pop, flush, full and empty.
  - Asynchronous active-low reset.
  - Flush has priority over push.

## Test plan
- Reset, then `en`=1 with zero-wait memory returning 0xA0000001 and 0xA0000002: `mem_addr` 0x0000 then 0x0004; `ir`=0xA0000001 with one `cs` pulse; the second issue happens only after `ready1` goes 1→0→1 plus the guard cycle.
- `ready1` held at 0 while the buffer fills: with `FETCH_PREFETCH_EN`, exactly 2 fetches happen (`pc`=0x0008), then `mem_req` stays low; without it, exactly 1 fetch (`pc`=0x0004).
- `br_valid` with `br_target`=0x0100 while a request to 0x0008 is outstanding with 3-cycle ack: the ack data is discarded, no `cs` occurs for it, and the next `mem_addr` is 0x0100.
- `br_valid` in the same cycle as a pending `cs` issue: `cs` stays 0, the buffer is empty next cycle, and `pc`=`br_target`.
- `pc` at 0xFFFC with `AW`=16: after the fetch, `pc`=0x0000.
- `rst_n` pulsed low during F_REQ: `mem_req`=0 and `cs`=0 immediately, and `pc`=`RESET_PC` on release.
